div_seq: RTL and testbench

Iterative 32-bit divide sequencer for the execute stage. It accepts a DIV/DIVU request from E and runs a radix-2 restoring division over 32 iterations. It drives the divider stall into the hazard unit (its stall_divE input) and returns {remainder, quotient} for the HI/LO write path. An annul input aborts the operation on pipeline flush (flushALL).

---
 rtl/div_seq.sv | 118 +++++++++++
 tb/tb_div_seq.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
// Optional macro DIV_EARLY_EXIT_EN: skip iteration when |dividend| < |divisor|.
//
// state    | meaning
// S_IDLE   | waiting for a divide request; operands latched on accept
// S_BYZERO | divisor was zero; build the fixed by-zero result
// S_ON     | one restoring iteration per cycle, 32 iterations
// S_END    | result valid for one cycle, then back to S_IDLE
module div_seq #(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic                 signed_i,
   input  logic [WIDTH-1:0]     opdata1_i,
   input  logic [WIDTH-1:0]     opdata2_i,
   input  logic                 annul_i,
   output logic                 stall_o,
   output logic                 ready_o,
   output logic [2*WIDTH-1:0]   result_o
);

   typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_t;

   state_t             state;
   logic [2*WIDTH:0]   work;
   logic [WIDTH-1:0]   divisor;
   logic [5:0]         cnt;
   logic               negq;
   logic               negr;

   logic [WIDTH-1:0]   abs1;
   logic [WIDTH-1:0]   abs2;
   logic [2*WIDTH:0]   shifted;
   logic [WIDTH+1:0]   diff;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quo;

   assign abs1    = (signed_i && opdata1_i[WIDTH-1]) ? -opdata1_i : opdata1_i;
   assign abs2    = (signed_i && opdata2_i[WIDTH-1]) ? -opdata2_i : opdata2_i;
   assign shifted = {work[2*WIDTH-1:0], 1'b0};
   // 34-bit difference so the borrow lands in the top bit
   assign diff    = {1'b0, shifted[2*WIDTH:WIDTH]} - {2'b00, divisor};

   assign ready_o = (state == S_END);
   assign stall_o = start_i & ~ready_o & ~annul_i;
   assign rem     = work[2*WIDTH-1:WIDTH];
   assign quo     = work[WIDTH-1:0];

   always_comb begin
      result_o = '0;
      if (state == S_END) begin
         result_o = {(negr ? -rem : rem), (negq ? -quo : quo)};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         work    <= '0;
         divisor <= '0;
         cnt     <= '0;
         negq    <= 1'b0;
         negr    <= 1'b0;
      end else if (annul_i) begin
         state <= S_IDLE;
      end else begin
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  divisor <= abs2;
                  cnt     <= '0;
                  negq    <= signed_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
                  negr    <= signed_i & opdata1_i[WIDTH-1];
                  if (opdata2_i == '0) begin
                     // by-zero result keeps the raw dividend and skips sign fixup
                     work  <= {{(WIDTH+1){1'b0}}, opdata1_i};
                     negq  <= 1'b0;
                     negr  <= 1'b0;
                     state <= S_BYZERO;
                  end
`ifdef DIV_EARLY_EXIT_EN
                  else if (abs1 < abs2) begin
                     work  <= {1'b0, abs1, {WIDTH{1'b0}}};
                     state <= S_END;
                  end
`endif
                  else begin
                     work  <= {{(WIDTH+1){1'b0}}, abs1};
                     state <= S_ON;
                  end
               end
            end
            S_BYZERO: begin
               work  <= {1'b0, work[WIDTH-1:0], {WIDTH{1'b1}}};
               state <= S_END;
            end
            S_ON: begin
               if (!diff[WIDTH+1]) begin
                  work <= {diff[WIDTH:0], shifted[WIDTH-1:1], 1'b1};
               end else begin
                  work <= shifted;
               end
               cnt <= cnt + 6'd1;
               if (cnt == 6'd31) begin
                  state <= S_END;
               end
            end
            S_END: begin
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq; expected results are hand-computed.
module tb_div_seq;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic        signed_i;
   logic [31:0] opdata1_i;
   logic [31:0] opdata2_i;
   logic        annul_i;
   logic        stall_o;
   logic        ready_o;
   logic [63:0] result_o;

   int checks = 0;
   int errors = 0;

`ifdef DIV_EARLY_EXIT_EN
   localparam int EE_CYC = 1;
`else
   localparam int EE_CYC = 33;
`endif

   div_seq #(.WIDTH(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start_i),
      .signed_i  (signed_i),
      .opdata1_i (opdata1_i),
      .opdata2_i (opdata2_i),
      .annul_i   (annul_i),
      .stall_o   (stall_o),
      .ready_o   (ready_o),
      .result_o  (result_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Starts a divide in the current cycle (cycle 0) and checks every cycle up to ready.
   task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int rdy_cyc);
      signed_i  = sg;
      opdata1_i = a;
      opdata2_i = b;
      start_i   = 1'b1;
      annul_i   = 1'b0;
      for (int c = 0; c <= rdy_cyc; c++) begin
         @(negedge clk);
         if (c < rdy_cyc) begin
            chk("busy_stall", stall_o, 64'd1);
            chk("busy_ready", ready_o, 64'd0);
            chk("busy_result", result_o, 64'd0);
         end else begin
            chk("done_ready", ready_o, 64'd1);
            chk("done_result", result_o, exp);
            chk("done_stall", stall_o, 64'd0);
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      rst = 1'b1; start_i = 1'b0; signed_i = 1'b0;
      opdata1_i = '0; opdata2_i = '0; annul_i = 1'b0;
      #2;
      chk("rst_stall", stall_o, 64'd0);
      chk("rst_ready", ready_o, 64'd0);
      chk("rst_result", result_o, 64'd0);
      #10 rst = 1'b0;
      @(posedge clk);
      #1;

      run_div(1'b0, 32'd100, 32'd7, {32'h2, 32'hE}, 33);
      run_div(1'b1, 32'hFFFFFFF9, 32'h2, {32'hFFFFFFFF, 32'hFFFFFFFD}, 33);
      run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 33);
      run_div(1'b0, 32'h12345678, 32'h0, {32'h12345678, 32'hFFFFFFFF}, 2);

      // annul at cycle 10, then a new DIVU 9/3 from cycle 11
      signed_i = 1'b0; opdata1_i = 32'd1000; opdata2_i = 32'd3; start_i = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         chk("pre_annul_stall", stall_o, 64'd1);
         chk("pre_annul_ready", ready_o, 64'd0);
         @(posedge clk);
         #1;
      end
      annul_i = 1'b1;
      @(negedge clk);
      chk("annul_stall", stall_o, 64'd0);
      chk("annul_ready", ready_o, 64'd0);
      @(posedge clk);
      #1;
      run_div(1'b0, 32'd9, 32'd3, {32'h0, 32'h3}, 33);

      // back-to-back with start held, then a third divide reset at its cycle 20
      run_div(1'b0, 32'd50, 32'd5, {32'h0, 32'd10}, 33);
      run_div(1'b0, 32'd81, 32'd9, {32'h0, 32'd9}, 33);
      opdata1_i = 32'd1000; opdata2_i = 32'd3;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("third_stall", stall_o, 64'd1);
         @(posedge clk);
         #1;
      end
      #2;
      rst = 1'b1; start_i = 1'b0;
      #1;
      chk("midrst_stall", stall_o, 64'd0);
      chk("midrst_ready", ready_o, 64'd0);
      chk("midrst_result", result_o, 64'd0);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;

      // reset while the result is on the outputs must clear them without a clock
      signed_i = 1'b0; opdata1_i = 32'hCAFEF00D; opdata2_i = 32'h0; start_i = 1'b1;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      chk("end_ready", ready_o, 64'd1);
      chk("end_result", result_o, {32'hCAFEF00D, 32'hFFFFFFFF});
      #2;
      rst = 1'b1; start_i = 1'b0;
      #1;
      chk("endrst_ready", ready_o, 64'd0);
      chk("endrst_result", result_o, 64'd0);
      #2 rst = 1'b0;
      @(posedge clk);
      #1;

      run_div(1'b0, 32'd3, 32'd10, {32'd3, 32'd0}, EE_CYC);
      run_div(1'b1, 32'hFFFFFFFD, 32'd10, {32'hFFFFFFFD, 32'h0}, EE_CYC);
      start_i = 1'b0;
      @(negedge clk);
      chk("idle_stall", stall_o, 64'd0);
      chk("idle_ready", ready_o, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
